// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-source round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    // Mux select index of each source: {s1,s0}
    localparam logic [SEL_W-1:0] SEL_A = 2'd0;
    localparam logic [SEL_W-1:0] SEL_B = 2'd1;
    localparam logic [SEL_W-1:0] SEL_C = 2'd2;
    localparam logic [SEL_W-1:0] SEL_D = 2'd3;

    // IDLE: no word held.  HOLD: out_data holds an unconsumed word.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set bit of elig at
// base, base+1, ... wrapping modulo 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_SRC-1:0] elig,
    input  logic [SEL_W-1:0] base,
    output logic             found,
    output logic [SEL_W-1:0] winner
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible source wins;
    // the 2-bit index sum wraps modulo 4 on its own.
    always_comb begin
        found  = |elig;
        winner = base;
        idx    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = base + SEL_W'(i);
            if (elig[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 data path among sources a..d,
// presenting the selected word on a registered valid/ready port.
//
// Handshake: a word transfers on any rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the word, its
// source index and the select lines stay frozen.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [N_SRC-1:0] gnt,
    output logic             s0,
    output logic             s1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_src,
    output arb_state_e       dbg_state
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;

    logic [N_SRC-1:0] elig;
    logic [SEL_W-1:0] base;
    logic             found;
    logic [SEL_W-1:0] winner;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    rr_pick4 u_pick (
        .elig   (elig),
        .base   (base),
        .found  (found),
        .winner (winner)
    );

    // Data path mux driven by the current pick
    always_comb begin
        case (winner)
            SEL_A:   sel_data = a;
            SEL_B:   sel_data = b;
            SEL_C:   sel_data = c;
            default: sel_data = d;
        endcase
    end

    // Next-state logic: pick in IDLE, or on a handshake with the source just
    // granted masked out (its req is still high for one cycle after gnt).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        valid_d = valid_q;
        gnt_d   = '0;
        elig    = '0;
        base    = ptr_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                elig = req;
                base = ptr_q;
                load = found;
            end
            HOLD: begin
                if (out_ready) begin
                    ptr_d = src_q + 1'b1;
                    base  = src_q + 1'b1;
                    elig  = req & ~(N_SRC'(1) << src_q);
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = HOLD;
            valid_d = 1'b1;
            src_d   = winner;
            data_d  = sel_data;
            gnt_d   = N_SRC'(1) << winner;
        end
    end

    // State and output registers; reset discards any held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign s1        = src_q[1];
    assign s0        = src_q[0];
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector tables, a reset-mid-HOLD
// sequence, and a randomized run against a behavioural reference model.
module tb_mux4_rr_arbiter;
  import mux4_arb_pkg::*;

  localparam int W  = 4;
  localparam int EW = 4 + 1 + 2 + W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic out_ready;
  logic [W-1:0] src_data [4];
  wire  [W-1:0] a = src_data[0];
  wire  [W-1:0] b = src_data[1];
  wire  [W-1:0] c = src_data[2];
  wire  [W-1:0] d = src_data[3];
  logic [3:0] gnt;
  logic s0, s1, out_valid;
  logic [W-1:0] out_data;
  logic [1:0] out_src;
  arb_state_e dbg_state;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .s0(s0), .s1(s1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare outputs after an edge against the oldest expected record
  task automatic check_out(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no expected record queued", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".outs"}, 32'({gnt, out_valid, out_src, out_data}), 32'(e));
      chk({name, ".sel"}, 32'({s1, s0}), 32'(e[W+1:W]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] r, input logic rdy, input string name);
    req = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic         pre_rst;
    logic [3:0]   req;
    logic         rdy;
    logic [3:0]   gnt;
    logic         v;
    logic [1:0]   src;
    logic [W-1:0] data;
    string        name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pr, input logic [3:0] r, input logic rdy,
                              input logic [3:0] g, input logic v, input logic [1:0] s,
                              input logic [W-1:0] dt, input string nm);
    vec_t x;
    x.pre_rst = pr; x.req = r; x.rdy = rdy; x.gnt = g; x.v = v;
    x.src = s; x.data = dt; x.name = nm;
    vecs.push_back(x);
  endfunction

  // ---------------- reference model ----------------
  bit         m_held;
  int         m_ptr, m_src;
  logic [W-1:0] m_data;

  function automatic int rr_first(input logic [3:0] elig, input int base);
    for (int k = 0; k < 4; k++) begin
      if (elig[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  // Predict the outputs after the coming edge from the current inputs
  function automatic void model_push();
    logic [3:0] eg = '0;
    logic [3:0] g = '0;
    int base = 0;
    int w;
    bit pick = 0;
    if (!m_held) begin
      eg = req; base = m_ptr; pick = 1;
    end else if (out_ready) begin
      m_ptr = (m_src + 1) % 4;
      eg = req; eg[m_src] = 1'b0;
      base = m_ptr; pick = 1;
      m_held = 0;
    end
    if (pick) begin
      w = rr_first(eg, base);
      if (w >= 0) begin
        m_held = 1;
        m_src  = w;
        m_data = src_data[w];
        g[w]   = 1'b1;
      end
    end
    exp_q.push_back({g, m_held, 2'(m_src), m_data});
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] seen;
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    src_data[0] = 4'h2; src_data[1] = 4'h9; src_data[2] = 4'hE; src_data[3] = 4'h3;

    // single request to c
    add(1, 4'b0100, 1, 4'b0100, 1, 2'd2, 4'hE, "single.grant");
    add(0, 4'b0100, 1, 4'b0000, 0, 2'd2, 4'hE, "single.drain");
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 4'hE, "single.idle");
    // all four, each drops one cycle after its gnt
    add(1, 4'b1111, 1, 4'b0001, 1, 2'd0, 4'h2, "all.a");
    add(0, 4'b1111, 1, 4'b0010, 1, 2'd1, 4'h9, "all.b");
    add(0, 4'b1110, 1, 4'b0100, 1, 2'd2, 4'hE, "all.c");
    add(0, 4'b1100, 1, 4'b1000, 1, 2'd3, 4'h3, "all.d");
    add(0, 4'b1000, 1, 4'b0000, 0, 2'd3, 4'h3, "all.drain");
    // backpressure on b
    add(1, 4'b0010, 0, 4'b0010, 1, 2'd1, 4'h9, "bp.grant");
    add(0, 4'b0010, 0, 4'b0000, 1, 2'd1, 4'h9, "bp.hold1");
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 4'h9, "bp.hold2");
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 4'h9, "bp.hold3");
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 4'h9, "bp.hold4");
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 4'h9, "bp.hold5");
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 4'h9, "bp.drain");
    // fairness a/d with continuous requests, ptr wraps 3 -> 0
    add(1, 4'b1001, 1, 4'b0001, 1, 2'd0, 4'h2, "fair.a1");
    add(0, 4'b1001, 1, 4'b1000, 1, 2'd3, 4'h3, "fair.d1");
    add(0, 4'b1001, 1, 4'b0001, 1, 2'd0, 4'h2, "fair.a2");
    add(0, 4'b1001, 1, 4'b1000, 1, 2'd3, 4'h3, "fair.d2");
    add(0, 4'b1001, 1, 4'b0001, 1, 2'd0, 4'h2, "fair.a3");
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'h2, "fair.drain");
    // a re-requests: second grant only after one out_valid=0 cycle
    add(1, 4'b0001, 1, 4'b0001, 1, 2'd0, 4'h2, "mask.grant1");
    add(0, 4'b0001, 1, 4'b0000, 0, 2'd0, 4'h2, "mask.gap");
    add(0, 4'b0001, 1, 4'b0001, 1, 2'd0, 4'h2, "mask.grant2");
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'h2, "mask.drain");

    do_reset();
    chk("reset.outs", 32'({gnt, out_valid, s1, s0, out_src, out_data}), 32'd0);
    chk("reset.state", 32'(dbg_state), 32'(IDLE));

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) do_reset();
      exp_q.push_back({vecs[i].gnt, vecs[i].v, vecs[i].src, vecs[i].data});
      step(vecs[i].req, vecs[i].rdy, vecs[i].name);
    end

    // reset asserted mid-HOLD clears everything at once
    do_reset();
    exp_q.push_back({4'b1000, 1'b1, 2'd3, 4'h3});
    step(4'b1000, 1'b0, "rst.grant");
    exp_q.push_back({4'b0000, 1'b1, 2'd3, 4'h3});
    step(4'b0000, 1'b0, "rst.hold");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.async_outs", 32'({gnt, out_valid, s1, s0, out_src, out_data}), 32'd0);
    chk("rst.async_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.release_state", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back({4'b0000, 1'b0, 2'd0, 4'h0});
    step(4'b0000, 1'b1, "rst.idle");

    // randomized run against the model
    do_reset();
    m_held = 0; m_ptr = 0; m_src = 0; m_data = '0;
    seen = '0;
    req = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (seen[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          src_data[i] = W'($urandom);
          req[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      model_push();
      @(posedge clk);
      #1;
      check_out("rand");
      seen = gnt;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one 4-to-1 data path among four requesters (sources a, b, c, d). It picks one requesting source per transfer, drives the mux select lines s1/s0 for it, and registers the selected word onto a valid/ready output port. It sits between the source registers and the downstream consumer and replaces hand-driven select lines with a fair, handshaken schedule.

## Interface
- WIDTH, 4, data width of each source and of out_data
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per source; bit 0=a, 1=b, 2=c, 3=d; level, held until granted
- a, b, c, d  input  WIDTH each  source data; must be stable while the matching req is high
- gnt  output  4  one-hot grant pulse, one cycle, registered
- s0, s1  output  1 each  registered mux select of the current winner; index = {s1,s0}: 00=a, 01=b, 10=c, 11=d
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts the word when high with out_valid
- out_data  output  WIDTH  registered selected word
- out_src  output  2  index of the source that produced out_data

## Operation
- States: IDLE (no word held) and HOLD (word held, out_valid=1).
- Pick: rotating priority starting at pointer ptr (2 bits). The winner is the first set bit of the eligible requests at ptr, ptr+1, ... mod 4.
- IDLE with any req: on the next edge load out_data from the winner's input, set out_src={s1,s0}=winner, pulse gnt[winner], set out_valid, go to HOLD. IDLE with no req: stay; gnt=0.
- HOLD with out_ready=0: hold out_data, out_src, s1/s0 and out_valid unchanged; gnt=0; ignore req.
- HOLD with out_ready=1 (handshake): ptr <= out_src+1 mod 4. The eligible set this cycle is req with bit out_src masked, because the requester drops req only one cycle after its gnt.
  - Any eligible req: reload the next winner back-to-back (new out_data, new gnt pulse, out_valid stays 1).
  - None: out_valid <= 0, go to IDLE.
- The masked pick in the handshake cycle uses the new base out_src+1.
- Requesters must deassert req the cycle after seeing their gnt. A req still high after that is a new request.
- out_data and out_src never change while out_valid=1 and out_ready=0.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, ptr=0, out_valid=0, out_data=0, out_src=0, s0=s1=0, gnt=0.
- Latency: req seen in IDLE at edge N gives gnt, out_valid and out_data at edge N+1.
- Throughput: one word per cycle while out_ready stays 1 and eligible requests exist.
- gnt is high for exactly one cycle, coincident with out_data changing to the granted word.
- Simultaneous requests: resolved by ptr only. No source waits more than 3 other transfers.
- Reset mid-transfer discards the held word. No gnt is issued during or directly out of reset.
- Single requester that re-requests continuously: served every other handshake cycle, because of the mask.

## Structure
- Shared package mux4_arb_pkg:
  - state enum {IDLE, HOLD}
  - N_SRC=4 and SEL_W=2
  - select-index constants SEL_A..SEL_D (0..3)
- Sub-module rr_pick4: combinational. Inputs are a 4-bit eligible vector and a 2-bit base; outputs are a found flag and a 2-bit winner index.
- Data select: one case on the winner index feeding the out_data register.

## Test plan
Sources for all scenarios: a=4'h2, b=4'h9, c=4'hE, d=4'h3.
- Reset: assert rst_n=0 mid-HOLD. Required: out_valid, gnt, s0, s1, out_data and out_src all 0 immediately; IDLE after release.
- Single request req=0100, out_ready=1. Required: next edge gnt=0100, out_data=4'hE, {s1,s0}=10, out_valid=1; following edge out_valid=0.
- All four request, out_ready=1, each requester drops req after its gnt. Required: grant order a, b, c, d; out_data 2, 9, E, 3 on consecutive cycles.
- Backpressure: req=0010, out_ready=0 for 5 cycles. Required: out_data=4'h9 and out_valid=1 held; gnt pulses only once.
- Fairness: req stays 1001 continuously, out_ready=1. Required: grants alternate a, d, a, d; ptr wraps from 3 to 0.
- Mask check: req=0001 held high two cycles past gnt, out_ready=1. Required: second grant to a only after one out_valid=0 cycle.
